// File: rtl/booth_seq_arbiter.sv
// ---------------------------------------------------------------------------
// booth_seq_arbiter
//
// Two-requester front end feeding a sequential radix-2 Booth multiplier.
// While idle, a round-robin arbiter picks one of the two requesters and
// accepts its signed operand pair. The product is then built one multiplier
// bit per cycle over WIDTH cycles and offered on a valid/ready response port
// together with the id of the requester that owns it.
//
// Ports
//   clk                     rising-edge clock for all state
//   rst                     synchronous active-high reset
//   req0_valid/req0_ready   requester 0 handshake
//   req0_x, req0_y          requester 0 multiplier / multiplicand (signed)
//   req1_valid/req1_ready   requester 1 handshake
//   req1_x, req1_y          requester 1 multiplier / multiplicand (signed)
//   rsp_valid/rsp_ready     response handshake
//   rsp_prod                2*WIDTH-bit signed product
//   rsp_id                  requester that owns rsp_prod
//   busy                    high whenever an operation is in flight
// ---------------------------------------------------------------------------
module booth_seq_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   input  logic [WIDTH-1:0]   req0_x,
   input  logic [WIDTH-1:0]   req0_y,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [WIDTH-1:0]   req1_x,
   input  logic [WIDTH-1:0]   req1_y,
   output logic               req1_ready,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2*WIDTH-1:0] rsp_prod,
   output logic               rsp_id,
   output logic               busy
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  x_q, x_d;
   logic [WIDTH-1:0]  y_q, y_d;
   logic              id_q, id_d;
   logic              lastGrant_q, lastGrant_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic              e_q, e_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]     rspProd_q, rspProd_d;
   logic              rspId_q, rspId_d;

   logic              grant0;
   logic              grant1;
   logic [PW-1:0]     yShift;
   logic              xBit;
   logic [PW-1:0]     stepAcc;

   // Round-robin pick between the two requesters. A lone valid always wins;
   // on a tie the requester that was not served last goes first. lastGrant
   // comes out of reset as 1 so requester 0 takes the very first tie.
   always_comb begin
      grant0 = req0_valid & (~req1_valid | lastGrant_q);
      grant1 = req1_valid & (~req0_valid | ~lastGrant_q);
   end

   // Readies are only ever offered from IDLE and are forced low while reset
   // is asserted, so nothing can be accepted during a reset cycle.
   assign req0_ready = ~rst & (state_q == IDLE) & grant0;
   assign req1_ready = ~rst & (state_q == IDLE) & grant1;

   assign rsp_valid  = (state_q == DONE);
   assign rsp_prod   = rspProd_q;
   assign rsp_id     = rspId_q;
   assign busy       = (state_q != IDLE);

   // One Booth step. The multiplicand is sign-extended to the full product
   // width before it is shifted into position, and the add/subtract wraps
   // modulo 2^(2*WIDTH), which is exactly what two's complement needs.
   // The bit pair {x[i], E} decides: 10 starts a run of ones (subtract),
   // 01 ends one (add), 00/11 leave the accumulator alone.
   always_comb begin
      yShift  = {{WIDTH{y_q[WIDTH-1]}}, y_q} << cnt_q;
      xBit    = x_q[cnt_q];
      stepAcc = acc_q;
      case ({xBit, e_q})
         2'b10:   stepAcc = acc_q - yShift;
         2'b01:   stepAcc = acc_q + yShift;
         default: stepAcc = acc_q;
      endcase
   end

   // Next-state and datapath update. Everything holds by default; the
   // response registers are only written on the last RUN step so they keep
   // showing the previous result through IDLE and RUN.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      id_d        = id_q;
      lastGrant_d = lastGrant_q;
      acc_d       = acc_q;
      e_d         = e_q;
      cnt_d       = cnt_q;
      rspProd_d   = rspProd_q;
      rspId_d     = rspId_q;

      case (state_q)
         IDLE: begin
            if (grant0) begin
               x_d         = req0_x;
               y_d         = req0_y;
               id_d        = 1'b0;
               lastGrant_d = 1'b0;
               acc_d       = '0;
               e_d         = 1'b0;
               cnt_d       = '0;
               state_d     = RUN;
            end else if (grant1) begin
               x_d         = req1_x;
               y_d         = req1_y;
               id_d        = 1'b1;
               lastGrant_d = 1'b1;
               acc_d       = '0;
               e_d         = 1'b0;
               cnt_d       = '0;
               state_d     = RUN;
            end
         end

         RUN: begin
            acc_d = stepAcc;
            e_d   = xBit;
            if (cnt_q == CW'(WIDTH - 1)) begin
               rspProd_d = stepAcc;
               rspId_d   = id_q;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register. Reset drops any operation in flight, clears the
   // datapath and the visible response, and re-arms the arbiter so that
   // requester 0 wins the first tie again.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         id_q        <= 1'b0;
         lastGrant_q <= 1'b1;
         acc_q       <= '0;
         e_q         <= 1'b0;
         cnt_q       <= '0;
         rspProd_q   <= '0;
         rspId_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         id_q        <= id_d;
         lastGrant_q <= lastGrant_d;
         acc_q       <= acc_d;
         e_q         <= e_d;
         cnt_q       <= cnt_d;
         rspProd_q   <= rspProd_d;
         rspId_q     <= rspId_d;
      end
   end

endmodule

// File: tb/tb_booth_seq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_arbiter
//
// Self-checking bench for booth_seq_arbiter (WIDTH = 4). A cycle-level
// reference model runs on the falling edge: it tracks arbitration, the
// RUN/DONE timing and the held response values, and pushes the expected
// {id, product} into a scoreboard queue whenever it predicts a handshake.
// Entries are popped and compared when the DUT completes a response.
// ---------------------------------------------------------------------------
module tb_booth_seq_arbiter;

   localparam int W = 4;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   typedef struct {
      logic         id;
      logic [2*W-1:0] prod;
   } exp_t;

   logic           clk;
   logic           rst;
   logic           req0_valid;
   logic [W-1:0]   req0_x;
   logic [W-1:0]   req0_y;
   logic           req0_ready;
   logic           req1_valid;
   logic [W-1:0]   req1_x;
   logic [W-1:0]   req1_y;
   logic           req1_ready;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [2*W-1:0] rsp_prod;
   logic           rsp_id;
   logic           busy;

   int             checkCount = 0;
   int             errorCount = 0;

   exp_t           expQ[$];
   int             servedIds[$];
   logic [2*W-1:0] lastRspProd;
   logic           lastRspId;

   int             mState;
   int             mCnt;
   logic           mLast;
   logic [2*W-1:0] holdProd;
   logic           holdId;
   logic           expR0;
   logic           expR1;
   exp_t           item;

   booth_seq_arbiter #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_x     (req0_x),
      .req0_y     (req0_y),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_x     (req1_x),
      .req1_y     (req1_y),
      .req1_ready (req1_ready),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_prod   (rsp_prod),
      .rsp_id     (rsp_id),
      .busy       (busy)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Signed reference product, written as a plain multiply of the
   // sign-extended operands.
   function automatic logic [2*W-1:0] refProd(input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      logic signed [2*W-1:0] sa;
      logic signed [2*W-1:0] sb;
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
   endfunction

   // Move to just after the next rising edge, where inputs are driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model and scoreboard. Checks the current cycle's outputs
   // against the model, then advances the model using the sampled inputs.
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("rstReady0", 32'(req0_ready), 32'd0);
         checkOutput("rstReady1", 32'(req1_ready), 32'd0);
         mState   = M_IDLE;
         mCnt     = 0;
         mLast    = 1'b1;
         holdProd = '0;
         holdId   = 1'b0;
         expQ.delete();
      end else begin
         expR0 = (mState == M_IDLE) && req0_valid && (!req1_valid || mLast);
         expR1 = (mState == M_IDLE) && req1_valid && (!req0_valid || !mLast);
         checkOutput("ready0",   32'(req0_ready), 32'(expR0));
         checkOutput("ready1",   32'(req1_ready), 32'(expR1));
         checkOutput("busy",     32'(busy),       32'(mState != M_IDLE));
         checkOutput("rspValid", 32'(rsp_valid),  32'(mState == M_DONE));
         checkOutput("rspProdHold", 32'(rsp_prod), 32'(holdProd));
         checkOutput("rspIdHold",   32'(rsp_id),   32'(holdId));
         case (mState)
            M_IDLE: begin
               if (expR0) begin
                  item.id   = 1'b0;
                  item.prod = refProd(req0_x, req0_y);
                  expQ.push_back(item);
                  mLast  = 1'b0;
                  mState = M_RUN;
                  mCnt   = 0;
               end else if (expR1) begin
                  item.id   = 1'b1;
                  item.prod = refProd(req1_x, req1_y);
                  expQ.push_back(item);
                  mLast  = 1'b1;
                  mState = M_RUN;
                  mCnt   = 0;
               end
            end
            M_RUN: begin
               if (mCnt == W - 1) begin
                  mState = M_DONE;
                  if (expQ.size() > 0) begin
                     holdProd = expQ[0].prod;
                     holdId   = expQ[0].id;
                  end
               end else begin
                  mCnt++;
               end
            end
            default: begin
               if (rsp_ready) begin
                  checkOutput("rspQueued", 32'(expQ.size() > 0), 32'd1);
                  if (expQ.size() > 0) begin
                     item = expQ.pop_front();
                     checkOutput("rspProd", 32'(rsp_prod), 32'(item.prod));
                     checkOutput("rspId",   32'(rsp_id),   32'(item.id));
                  end
                  servedIds.push_back(int'(rsp_id));
                  lastRspProd = rsp_prod;
                  lastRspId   = rsp_id;
                  mState      = M_IDLE;
               end
            end
         endcase
      end
   end

   // Wait (bounded) for the given requester's handshake, sampled mid-cycle.
   task automatic waitGrant(input int id);
      logic got;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         got = (id == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
         if (!got) tick();
      end
      checkOutput("grantSeen", 32'(got), 32'd1);
   endtask

   // One transaction from a single requester. Operands are scrambled right
   // after acceptance; with rspDelay > 0 the consumer stalls that many DONE
   // cycles while both requesters keep asking.
   task automatic applyStimulus(input int id, input logic [W-1:0] a,
                                input logic [W-1:0] b, input int rspDelay);
      int  n;
      logic seen;
      rsp_ready = (rspDelay == 0);
      if (id == 0) begin
         req0_valid = 1'b1; req0_x = a; req0_y = b;
      end else begin
         req1_valid = 1'b1; req1_x = a; req1_y = b;
      end
      waitGrant(id);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_x = W'($urandom); req0_y = W'($urandom);
      req1_x = W'($urandom); req1_y = W'($urandom);
      n    = 0;
      seen = 1'b0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen = 1'b1;
            n    = c;
         end else begin
            tick();
         end
      end
      checkOutput("latency", 32'(n), 32'(W + 1));
      if (rspDelay > 0) begin
         req0_valid = 1'b1;
         req1_valid = 1'b1;
      end
      repeat (rspDelay) tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   // Both requesters valid continuously until n responses complete; each
   // requester gets fresh operands right after its own handshake. Response
   // ids must alternate starting with 'first'.
   task automatic runBoth(input int n, input int first);
      int   base;
      int   got;
      logic h0;
      logic h1;
      base       = servedIds.size();
      got        = 0;
      rsp_ready  = 1'b1;
      req0_valid = 1'b1; req0_x = 4'h2; req0_y = 4'h3;
      req1_valid = 1'b1; req1_x = 4'hE; req1_y = 4'h5;
      for (int c = 0; c < 400 && got < n; c++) begin
         @(negedge clk);
         h0 = req0_valid && req0_ready;
         h1 = req1_valid && req1_ready;
         if (rsp_valid && rsp_ready) got++;
         tick();
         if (h0) begin req0_x = W'($urandom); req0_y = W'($urandom); end
         if (h1) begin req1_x = W'($urandom); req1_y = W'($urandom); end
      end
      checkOutput("bothDone", 32'(got), 32'(n));
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         checkOutput("order",
                     32'((base + k < servedIds.size()) ? servedIds[base + k] : 99),
                     32'((first + k) % 2));
      end
   endtask

   initial begin
      rst        = 1'b1;
      req0_valid = 1'b0; req0_x = '0; req0_y = '0;
      req1_valid = 1'b0; req1_x = '0; req1_y = '0;
      rsp_ready  = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("resetBusy",     32'(busy),      32'd0);
      checkOutput("resetRspValid", 32'(rsp_valid), 32'd0);
      checkOutput("resetRspProd",  32'(rsp_prod),  32'd0);
      checkOutput("resetRspId",    32'(rsp_id),    32'd0);
      tick();

      $display("[TB] directed products");
      applyStimulus(0, 4'h3, 4'h5, 0);
      checkOutput("prod3x5",   32'(lastRspProd), 32'h0F);
      checkOutput("id3x5",     32'(lastRspId),   32'd0);
      applyStimulus(1, 4'hD, 4'h7, 0);
      checkOutput("prodM3x7",  32'(lastRspProd), 32'hEB);
      checkOutput("idM3x7",    32'(lastRspId),   32'd1);
      applyStimulus(0, 4'h8, 4'h8, 0);
      checkOutput("prodM8xM8", 32'(lastRspProd), 32'h40);

      $display("[TB] consumer stall in DONE");
      applyStimulus(1, 4'h7, 4'h8, 3);
      checkOutput("prod7xM8",  32'(lastRspProd), 32'hC8);
      checkOutput("id7xM8",    32'(lastRspId),   32'd1);

      $display("[TB] round robin after reset");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      runBoth(4, 0);

      $display("[TB] reset during RUN");
      req0_valid = 1'b1; req0_x = 4'h5; req0_y = 4'h6;
      waitGrant(0);
      tick();
      req0_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abortBusy",     32'(busy),      32'd0);
      checkOutput("abortRspValid", 32'(rsp_valid), 32'd0);
      checkOutput("abortRspProd",  32'(rsp_prod),  32'd0);
      checkOutput("abortRspId",    32'(rsp_id),    32'd0);
      tick();
      runBoth(1, 0);

      $display("[TB] random traffic");
      for (int c = 0; c < 400; c++) begin
         req0_valid = 1'($urandom_range(0, 1));
         req1_valid = 1'($urandom_range(0, 1));
         req0_x     = W'($urandom);
         req0_y     = W'($urandom);
         req1_x     = W'($urandom);
         req1_y     = W'($urandom);
         rsp_ready  = ($urandom_range(0, 3) != 0);
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      repeat (12) tick();
      checkOutput("drained", 32'(expQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
